// File: rtl/vsw_pkg.sv
// Shared types and constants for the frame-synchronous video source switch.
package vsw_pkg;

   typedef enum logic [1:0] {
      VSW_RUN      = 2'd0,
      VSW_WAIT_EOF = 2'd1,
      VSW_BLANK    = 2'd2
   } vsw_state_e;

   localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/video_src_switch_if.sv
// RGB + sync video bundle carrying N streams of DW-bit colour components.
// Stream k occupies [k*DW +: DW] of r/g/b and bit k of each timing vector.
interface video_src_switch_if #(
   parameter int unsigned N  = 1,
   parameter int unsigned DW = 8
);
   logic [N*DW-1:0] r;
   logic [N*DW-1:0] g;
   logic [N*DW-1:0] b;
   logic [N-1:0]    hsync;
   logic [N-1:0]    vsync;
   logic [N-1:0]    line_valid;
   logic [N-1:0]    frame_valid;

   modport master (output r, g, b, hsync, vsync, line_valid, frame_valid);
   modport slave  (input  r, g, b, hsync, vsync, line_valid, frame_valid);
endinterface

// File: rtl/vsw_ctrl.sv
// Switch controller: RUN / WAIT_EOF / BLANK FSM, active and pending selects,
// blank-frame counter. Optional watchdog built only with VSW_WATCHDOG_EN.
module vsw_ctrl
   import vsw_pkg::*;
#(
   parameter int unsigned NUM_SRC      = 8,
   parameter int unsigned SEL_W        = 4,
   parameter int unsigned BLANK_FRAMES = 1,
   parameter int unsigned TIMEOUT_CYC  = 4194304
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] sel,
   input  logic             fv_active,
   input  logic             fv_pending,
   output logic [SEL_W-1:0] active_sel,
   output logic [SEL_W-1:0] pending_sel,
   output logic             blank,
   output logic             switching
);

   localparam logic [15:0] BLANK_LIM = 16'(BLANK_FRAMES);

   vsw_state_e       state_q, state_d;
   logic [SEL_W-1:0] active_q, active_d;
   logic [SEL_W-1:0] pending_q, pending_d;
   logic [15:0]      blank_cnt_q, blank_cnt_d;
   logic             fv_prev_q, fv_prev_d;
   logic             switching_q;
   logic             commit;
   logic             sel_ok;
   logic             eof;
`ifdef VSW_WATCHDOG_EN
   logic [31:0]      wd_q, wd_d;
`endif

   assign sel_ok = 32'(sel) < NUM_SRC;
   assign eof    = fv_prev_q & ~fv_active;

   // Next-state logic: switch request, cancel, commit and blank-frame accounting.
   always_comb begin
      state_d     = state_q;
      active_d    = active_q;
      pending_d   = pending_q;
      blank_cnt_d = blank_cnt_q;
      commit      = 1'b0;
      case (state_q)
         VSW_RUN: begin
            if (sel_ok && (sel != active_q)) begin
               pending_d = sel;
               state_d   = VSW_WAIT_EOF;
            end
         end
         VSW_WAIT_EOF: begin
            if (sel == active_q) begin
               state_d = VSW_RUN;
            end else begin
               if (!fv_active && !fv_pending) commit = 1'b1;
`ifdef VSW_WATCHDOG_EN
               if (wd_q == 32'(TIMEOUT_CYC - 1)) commit = 1'b1;
`endif
               if (commit) begin
                  active_d    = pending_q;
                  blank_cnt_d = '0;
                  state_d     = (BLANK_FRAMES > 0) ? VSW_BLANK : VSW_RUN;
               end else if (sel_ok) begin
                  pending_d = sel;
               end
            end
         end
         VSW_BLANK: begin
            if (blank_cnt_q == BLANK_LIM) begin
               state_d = VSW_RUN;
            end else if (eof) begin
               blank_cnt_d = blank_cnt_q + 16'd1;
            end
         end
         default: state_d = VSW_RUN;
      endcase
      // A watchdog commit can leave the old source mid-frame; never carry its FV across.
      fv_prev_d = commit ? 1'b0 : fv_active;
   end

`ifdef VSW_WATCHDOG_EN
   // Watchdog counts cycles spent in WAIT_EOF and is zero on every entry.
   assign wd_d = (state_q == VSW_WAIT_EOF) ? wd_q + 32'd1 : 32'd0;
`endif

   // State and select registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= VSW_RUN;
         active_q    <= '0;
         pending_q   <= '0;
         blank_cnt_q <= '0;
         fv_prev_q   <= 1'b0;
         switching_q <= 1'b0;
`ifdef VSW_WATCHDOG_EN
         wd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         active_q    <= active_d;
         pending_q   <= pending_d;
         blank_cnt_q <= blank_cnt_d;
         fv_prev_q   <= fv_prev_d;
         switching_q <= (state_d != VSW_RUN);
`ifdef VSW_WATCHDOG_EN
         wd_q        <= wd_d;
`endif
      end
   end

   assign active_sel  = active_q;
   assign pending_sel = pending_q;
   assign blank       = (state_q == VSW_BLANK);
   assign switching   = switching_q;

endmodule

// File: rtl/video_src_switch.sv
// Frame-synchronous video source selector: wide source muxes, one-cycle output
// register with blanking, and output frame counter. Optional watchdog inside
// the controller is enabled by defining VSW_WATCHDOG_EN.
module video_src_switch
   import vsw_pkg::*;
#(
   parameter int unsigned NUM_SRC      = 8,
   parameter int unsigned DW           = 8,
   parameter int unsigned SEL_W        = 4,
   parameter int unsigned BLANK_FRAMES = 1,
   parameter int unsigned TIMEOUT_CYC  = 4194304
) (
   input  logic                   clk,
   input  logic                   rst,
   video_src_switch_if.slave      src,
   video_src_switch_if.master     sink,
   input  logic [SEL_W-1:0]       sel,
   output logic [SEL_W-1:0]       active_sel,
   output logic                   switching,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   logic [SEL_W-1:0]       pending_sel;
   logic                   blank;
   logic [DW-1:0]          mux_r, mux_g, mux_b;
   logic                   mux_hs, mux_vs, mux_lv, mux_fv;
   logic                   fv_pending;
   logic                   fv_next;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   vsw_ctrl #(
      .NUM_SRC      (NUM_SRC),
      .SEL_W        (SEL_W),
      .BLANK_FRAMES (BLANK_FRAMES),
      .TIMEOUT_CYC  (TIMEOUT_CYC)
   ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .sel         (sel),
      .fv_active   (mux_fv),
      .fv_pending  (fv_pending),
      .active_sel  (active_sel),
      .pending_sel (pending_sel),
      .blank       (blank),
      .switching   (switching)
   );

   // Select the active source's pixel/timing and the pending source's frame valid.
   always_comb begin
      mux_r      = '0;
      mux_g      = '0;
      mux_b      = '0;
      mux_hs     = 1'b0;
      mux_vs     = 1'b0;
      mux_lv     = 1'b0;
      mux_fv     = 1'b0;
      fv_pending = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (active_sel == SEL_W'(k)) begin
            mux_r  = src.r[k*DW +: DW];
            mux_g  = src.g[k*DW +: DW];
            mux_b  = src.b[k*DW +: DW];
            mux_hs = src.hsync[k];
            mux_vs = src.vsync[k];
            mux_lv = src.line_valid[k];
            mux_fv = src.frame_valid[k];
         end
         if (pending_sel == SEL_W'(k)) fv_pending = src.frame_valid[k];
      end
   end

   assign fv_next = mux_fv & ~blank;

   // Output register; blanking zeroes colour and valids but keeps syncs running.
   always_ff @(posedge clk) begin
      if (rst) begin
         sink.r           <= '0;
         sink.g           <= '0;
         sink.b           <= '0;
         sink.hsync       <= '0;
         sink.vsync       <= '0;
         sink.line_valid  <= '0;
         sink.frame_valid <= '0;
      end else begin
         sink.r           <= blank ? '0 : mux_r;
         sink.g           <= blank ? '0 : mux_g;
         sink.b           <= blank ? '0 : mux_b;
         sink.hsync[0]    <= mux_hs;
         sink.vsync[0]    <= mux_vs;
         sink.line_valid[0]  <= mux_lv & ~blank;
         sink.frame_valid[0] <= fv_next;
      end
   end

   // Count output frame ends; bumps on the same edge the registered FV falls.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (sink.frame_valid[0] && !fv_next) begin
         frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_video_src_switch.sv
// Directed bench for video_src_switch: reset, switch with blank frame, cancel,
// out-of-range select, watchdog (VSW_WATCHDOG_EN) and reset during BLANK.
module tb_video_src_switch;
   import vsw_pkg::*;

   localparam int unsigned NUM_SRC = 8;
   localparam int unsigned DW      = 8;
   localparam int unsigned SEL_W   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [SEL_W-1:0] sel = '0;
   logic [SEL_W-1:0] active_sel;
   logic switching;
   logic [FRAME_CNT_W-1:0] frame_cnt;
   logic [NUM_SRC-1:0] fv = '0;
   logic [NUM_SRC-1:0] hs = '0;
   logic [NUM_SRC*DW-1:0] rr, gg, bb;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   video_src_switch_if #(.N(NUM_SRC), .DW(DW)) src_if ();
   video_src_switch_if #(.N(1), .DW(DW)) sink_if ();

   assign src_if.r           = rr;
   assign src_if.g           = gg;
   assign src_if.b           = bb;
   assign src_if.hsync       = hs;
   assign src_if.vsync       = '0;
   assign src_if.line_valid  = fv;
   assign src_if.frame_valid = fv;

   video_src_switch #(
      .NUM_SRC (NUM_SRC), .DW (DW), .SEL_W (SEL_W), .BLANK_FRAMES (1), .TIMEOUT_CYC (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .src        (src_if.slave),
      .sink       (sink_if.master),
      .sel        (sel),
      .active_sel (active_sel),
      .switching  (switching),
      .frame_cnt  (frame_cnt)
   );

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      for (int k = 0; k < NUM_SRC; k++) begin
         rr[k*DW +: DW] = 8'h12 + 8'(k * 16);
         gg[k*DW +: DW] = 8'h34 + 8'(k * 16);
         bb[k*DW +: DW] = 8'h56 + 8'(k * 16);
      end
      fv = 8'b0000_0001;
      rst = 1'b1;
      step(3);
      vectors++; if (sink_if.r !== 8'h00 || sink_if.frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out r=%h fv=%b want 00/0", sink_if.r, sink_if.frame_valid); end
      vectors++; if (active_sel !== 4'd0 || switching !== 1'b0 || frame_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_ctrl act=%0d sw=%b cnt=%0d want 0/0/0", active_sel, switching, frame_cnt); end
      rst = 1'b0;
      step();
      vectors++; if ({sink_if.r, sink_if.g, sink_if.b} !== 24'h123456) begin miscompares++; $display("FAIL reset_pix got %h want 123456", {sink_if.r, sink_if.g, sink_if.b}); end
      vectors++; if (sink_if.frame_valid !== 1'b1 || sink_if.line_valid !== 1'b1) begin miscompares++; $display("FAIL reset_fv got fv=%b lv=%b want 1/1", sink_if.frame_valid, sink_if.line_valid); end
   endtask

   task automatic test_switch;
      hs = 8'b0000_1000;
      fv = 8'b0000_1001;
      sel = 4'd3;
      step();
      vectors++; if (switching !== 1'b1 || active_sel !== 4'd0 || sink_if.r !== 8'h12) begin miscompares++; $display("FAIL sw_wait sw=%b act=%0d r=%h want 1/0/12", switching, active_sel, sink_if.r); end
      fv = 8'b0000_1000;
      step();
      vectors++; if (sink_if.frame_valid !== 1'b0 || frame_cnt !== 16'd1 || active_sel !== 4'd0) begin miscompares++; $display("FAIL sw_src0_eof fv=%b cnt=%0d act=%0d want 0/1/0", sink_if.frame_valid, frame_cnt, active_sel); end
      fv = 8'b0000_0000;
      step();
      vectors++; if (active_sel !== 4'd3 || sink_if.r !== 8'h12) begin miscompares++; $display("FAIL sw_commit act=%0d r=%h want 3/12", active_sel, sink_if.r); end
      step();
      vectors++; if (sink_if.r !== 8'h00 || sink_if.hsync !== 1'b1 || switching !== 1'b1) begin miscompares++; $display("FAIL sw_blank_start r=%h hs=%b sw=%b want 00/1/1", sink_if.r, sink_if.hsync, switching); end
      fv = 8'b0000_1000;
      step(4);
      vectors++; if ({sink_if.r, sink_if.g, sink_if.b} !== 24'h0 || sink_if.frame_valid !== 1'b0 || sink_if.line_valid !== 1'b0) begin miscompares++; $display("FAIL sw_blank_frame rgb=%h fv=%b lv=%b want 0/0/0", {sink_if.r, sink_if.g, sink_if.b}, sink_if.frame_valid, sink_if.line_valid); end
      fv = 8'b0000_0000;
      step();
      vectors++; if (switching !== 1'b1 || sink_if.r !== 8'h00) begin miscompares++; $display("FAIL sw_blank_eof sw=%b r=%h want 1/00", switching, sink_if.r); end
      step();
      vectors++; if (switching !== 1'b0 || sink_if.r !== 8'h00) begin miscompares++; $display("FAIL sw_to_run sw=%b r=%h want 0/00", switching, sink_if.r); end
      step();
      vectors++; if ({sink_if.r, sink_if.g, sink_if.b} !== 24'h426486 || sink_if.frame_valid !== 1'b0) begin miscompares++; $display("FAIL sw_src3_idle rgb=%h fv=%b want 426486/0", {sink_if.r, sink_if.g, sink_if.b}, sink_if.frame_valid); end
      fv = 8'b0000_1000;
      step();
      vectors++; if (sink_if.frame_valid !== 1'b1 || sink_if.line_valid !== 1'b1 || frame_cnt !== 16'd1) begin miscompares++; $display("FAIL sw_src3_frame fv=%b lv=%b cnt=%0d want 1/1/1", sink_if.frame_valid, sink_if.line_valid, frame_cnt); end
      fv = 8'b0000_0000;
      step();
      vectors++; if (frame_cnt !== 16'd2) begin miscompares++; $display("FAIL sw_frame_cnt got %0d want 2", frame_cnt); end
   endtask

   task automatic test_cancel;
      fv = 8'b0010_1000;
      sel = 4'd5;
      step(2);
      vectors++; if (switching !== 1'b1 || active_sel !== 4'd3) begin miscompares++; $display("FAIL cancel_wait sw=%b act=%0d want 1/3", switching, active_sel); end
      sel = 4'd3;
      step();
      vectors++; if (switching !== 1'b0 || active_sel !== 4'd3) begin miscompares++; $display("FAIL cancel_run sw=%b act=%0d want 0/3", switching, active_sel); end
      fv = 8'b0000_0000;
      step(2);
      vectors++; if (active_sel !== 4'd3 || switching !== 1'b0 || sink_if.r !== 8'h42 || frame_cnt !== 16'd3) begin miscompares++; $display("FAIL cancel_noblank act=%0d sw=%b r=%h cnt=%0d want 3/0/42/3", active_sel, switching, sink_if.r, frame_cnt); end
   endtask

   task automatic test_out_of_range;
      fv = 8'b0000_1000;
      sel = 4'd12;
      step(2);
      vectors++; if (switching !== 1'b0 || active_sel !== 4'd3 || sink_if.r !== 8'h42) begin miscompares++; $display("FAIL oor_12 sw=%b act=%0d r=%h want 0/3/42", switching, active_sel, sink_if.r); end
      sel = 4'd8;
      step(2);
      vectors++; if (switching !== 1'b0 || active_sel !== 4'd3) begin miscompares++; $display("FAIL oor_8 sw=%b act=%0d want 0/3", switching, active_sel); end
   endtask

   task automatic test_watchdog;
      fv = 8'b0000_1000;
      sel = 4'd0;
      step();
      vectors++; if (switching !== 1'b1) begin miscompares++; $display("FAIL wd_enter sw=%b want 1", switching); end
`ifdef VSW_WATCHDOG_EN
      step(99);
      vectors++; if (active_sel !== 4'd3) begin miscompares++; $display("FAIL wd_before act=%0d want 3", active_sel); end
      step();
      vectors++; if (active_sel !== 4'd0) begin miscompares++; $display("FAIL wd_commit act=%0d want 0", active_sel); end
`else
      step(10000);
      vectors++; if (switching !== 1'b1 || active_sel !== 4'd3) begin miscompares++; $display("FAIL wd_stuck sw=%b act=%0d want 1/3", switching, active_sel); end
`endif
   endtask

   task automatic test_reset_in_blank;
      fv = 8'b0000_0000;
      step(2);
      vectors++; if (switching !== 1'b1 || active_sel !== 4'd0 || sink_if.r !== 8'h00) begin miscompares++; $display("FAIL rb_in_blank sw=%b act=%0d r=%h want 1/0/00", switching, active_sel, sink_if.r); end
      rst = 1'b1;
      step();
      vectors++; if (switching !== 1'b0 || active_sel !== 4'd0 || frame_cnt !== 16'd0) begin miscompares++; $display("FAIL rb_reset sw=%b act=%0d cnt=%0d want 0/0/0", switching, active_sel, frame_cnt); end
      rst = 1'b0;
      step();
      vectors++; if (sink_if.r !== 8'h12 || switching !== 1'b0) begin miscompares++; $display("FAIL rb_resume r=%h sw=%b want 12/0", sink_if.r, switching); end
   endtask

   initial begin
      test_reset();
      test_switch();
      test_cancel();
      test_out_of_range();
      test_watchdog();
      test_reset_in_blank();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
